// File: rtl/operand_bypass_pkg.sv
// Shared definitions for the operand bypass / hazard unit.
//   STG_E/STG_M/STG_W : indices of the tracked stages after decode
//   TNEW_W            : width of the "cycles until result valid" field
//   WA_MAX_W          : storage width of a destination address in a stage
//                       entry (instances use ADDR_W <= WA_MAX_W)
//   stage_entry_t     : one tracked in-flight instruction
//   tnew_dec()        : saturating decrement applied as an entry ages
package operand_bypass_pkg;

  localparam int STG_E    = 0;
  localparam int STG_M    = 1;
  localparam int STG_W    = 2;
  localparam int TNEW_W   = 2;
  localparam int WA_MAX_W = 8;

  typedef struct packed {
    logic                valid;
    logic                we;
    logic [WA_MAX_W-1:0] wa;
    logic [TNEW_W-1:0]   tnew;
  } stage_entry_t;

  function automatic logic [TNEW_W-1:0] tnew_dec(input logic [TNEW_W-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

endpackage

// File: rtl/operand_bypass_pick.sv
// Per-read-port priority search over the tracked stages.
//   entries    : registered stage entries (index 0 = youngest, E)
//   src_addr   : source register of this port
//   src_tuse   : cycles until this port consumes the operand
//   src_rfdata : register-file read data for this port
//   stage_data : result bus of every tracked stage
//   fwd        : bypassed operand
//   ready      : fwd is final
//   hazard     : producer cannot deliver in time, decode must stall
module bypass_pick
  import operand_bypass_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3
) (
  input  stage_entry_t [DEPTH-1:0] entries,
  input  logic [ADDR_W-1:0]        src_addr,
  input  logic [TNEW_W-1:0]        src_tuse,
  input  logic [DATA_W-1:0]        src_rfdata,
  input  logic [DEPTH*DATA_W-1:0]  stage_data,
  output logic [DATA_W-1:0]        fwd,
  output logic                     ready,
  output logic                     hazard
);

  logic [WA_MAX_W-1:0] addr_ext;
  logic                hit;
  logic [TNEW_W-1:0]   win_tnew;
  logic [DATA_W-1:0]   win_data;

  assign addr_ext = WA_MAX_W'(src_addr);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    hit      = 1'b0;
    win_tnew = '0;
    win_data = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (entries[k].valid && entries[k].we && (src_addr != '0) &&
          (entries[k].wa == addr_ext)) begin
        hit      = 1'b1;
        win_tnew = entries[k].tnew;
        win_data = stage_data[k*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    fwd    = src_rfdata;
    ready  = 1'b1;
    hazard = 1'b0;
    if (hit) begin
      if (win_tnew == '0) begin
        fwd = win_data;
      end else if (win_tnew <= src_tuse) begin
        // Result arrives before it is needed; a later cycle re-picks it.
        ready = 1'b0;
      end else begin
        ready  = 1'b0;
        hazard = 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_bypass.sv
// Operand bypass and stall generation for a pipeline with DEPTH tracked
// stages after decode.
//   clk, reset  : clock, synchronous active-high reset
//   issue_*     : instruction leaving decode (valid, we, wa, tnew)
//   flush       : kill the instruction entering E
//   src_addr/src_tuse/src_rfdata : NUM_SRC decode read ports, packed
//   stage_data  : result bus of each tracked stage, packed (index 0 = E)
//   src_fwd     : bypassed operand per port
//   src_ready   : per-port "src_fwd is final"
//   stall       : freeze PC/D and inject a bubble into E
module operand_bypass
  import operand_bypass_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      issue_valid,
  input  logic                      issue_we,
  input  logic [ADDR_W-1:0]         issue_wa,
  input  logic [1:0]                issue_tnew,
  input  logic                      flush,
  input  logic [NUM_SRC*ADDR_W-1:0] src_addr,
  input  logic [NUM_SRC*2-1:0]      src_tuse,
  input  logic [NUM_SRC*DATA_W-1:0] src_rfdata,
  input  logic [DEPTH*DATA_W-1:0]   stage_data,
  output logic [NUM_SRC*DATA_W-1:0] src_fwd,
  output logic [NUM_SRC-1:0]        src_ready,
  output logic                      stall
);

  stage_entry_t [DEPTH-1:0] stage_reg;
  stage_entry_t [DEPTH-1:0] stage_next;
  logic [NUM_SRC-1:0]       hazard;

  assign stall = |hazard;

  // Entry 0 takes the issuing instruction unless it is flushed or held in
  // decode by a stall; older entries age by one stage.
  always_comb begin
    stage_next        = stage_reg;
    stage_next[STG_E] = '0;
    if (issue_valid && !flush && !stall) begin
      stage_next[STG_E].valid = 1'b1;
      stage_next[STG_E].we    = issue_we;
      stage_next[STG_E].wa    = WA_MAX_W'(issue_wa);
      stage_next[STG_E].tnew  = issue_tnew;
    end
    for (int k = 1; k < DEPTH; k++) begin
      stage_next[k]      = stage_reg[k-1];
      stage_next[k].tnew = tnew_dec(stage_reg[k-1].tnew);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stage_reg <= '0;
    end else begin
      stage_reg <= stage_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_pick
      bypass_pick #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
      ) u_pick (
        .entries    (stage_reg),
        .src_addr   (src_addr[gi*ADDR_W +: ADDR_W]),
        .src_tuse   (src_tuse[gi*2 +: 2]),
        .src_rfdata (src_rfdata[gi*DATA_W +: DATA_W]),
        .stage_data (stage_data),
        .fwd        (src_fwd[gi*DATA_W +: DATA_W]),
        .ready      (src_ready[gi]),
        .hazard     (hazard[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_operand_bypass.sv
// Self-checking bench for operand_bypass: a timeline model of in-flight
// producers checked every cycle, plus directed literal expectations.
module tb_operand_bypass;

  localparam int DATA_W  = 32;
  localparam int ADDR_W  = 5;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 3;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      issue_valid;
  logic                      issue_we;
  logic [ADDR_W-1:0]         issue_wa;
  logic [1:0]                issue_tnew;
  logic                      flush;
  logic [NUM_SRC*ADDR_W-1:0] src_addr;
  logic [NUM_SRC*2-1:0]      src_tuse;
  logic [NUM_SRC*DATA_W-1:0] src_rfdata;
  logic [DEPTH*DATA_W-1:0]   stage_data;
  logic [NUM_SRC*DATA_W-1:0] src_fwd;
  logic [NUM_SRC-1:0]        src_ready;
  logic                      stall;

  always #5 clk = ~clk;

  operand_bypass #(
    .DATA_W (DATA_W), .ADDR_W (ADDR_W), .NUM_SRC (NUM_SRC), .DEPTH (DEPTH)
  ) dut (
    .clk (clk), .reset (reset),
    .issue_valid (issue_valid), .issue_we (issue_we), .issue_wa (issue_wa),
    .issue_tnew (issue_tnew), .flush (flush),
    .src_addr (src_addr), .src_tuse (src_tuse), .src_rfdata (src_rfdata),
    .stage_data (stage_data),
    .src_fwd (src_fwd), .src_ready (src_ready), .stall (stall)
  );

  // Model: each accepted producer is remembered with the absolute cycle it
  // sat in E and the absolute cycle its result becomes valid.
  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] wa;
    int                issue_cyc;
    int                ready_cyc;
  } rec_t;

  rec_t q[$];
  int   cyc = 0;
  bit   started = 0;
  logic exp_stall = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    rec_t r;
    if (reset) begin
      q.delete();
      started = 1;
    end else if (issue_valid && !flush && !exp_stall) begin
      r.we = issue_we;
      r.wa = issue_wa;
      r.issue_cyc = cyc + 1;
      r.ready_cyc = cyc + 1 + int'(issue_tnew);
      q.push_back(r);
    end
    cyc++;
    while (q.size() > 0 && (cyc - q[0].issue_cyc) >= DEPTH) q.delete(0);
  end

  always @(negedge clk) begin
    logic              st, er, hz, found;
    logic [31:0]       ef;
    logic [ADDR_W-1:0] a;
    int                tu, age, rem;
    st = 1'b0;
    for (int p = 0; p < NUM_SRC; p++) begin
      a  = src_addr[p*ADDR_W +: ADDR_W];
      tu = int'(src_tuse[p*2 +: 2]);
      ef = src_rfdata[p*DATA_W +: DATA_W];
      er = 1'b1;
      hz = 1'b0;
      found = 1'b0;
      if (a != 0) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (!found && q[i].we && q[i].wa == a) begin
            found = 1'b1;
            age = cyc - q[i].issue_cyc;
            rem = q[i].ready_cyc - cyc;
            if (rem < 0) rem = 0;
            if (rem == 0) ef = stage_data[age*DATA_W +: DATA_W];
            else begin
              er = 1'b0;
              if (rem > tu) hz = 1'b1;
            end
          end
        end
      end
      st = st | hz;
      if (started) begin
        chk($sformatf("model_fwd%0d", p), src_fwd[p*DATA_W +: DATA_W], ef);
        chk($sformatf("model_ready%0d", p), 32'(src_ready[p]), 32'(er));
      end
    end
    exp_stall = st;
    if (started) chk("model_stall", 32'(stall), 32'(st));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_we = 1'b0; issue_wa = '0; issue_tnew = '0;
    flush = 1'b0;
  endtask

  task automatic drain();
    idle();
    src_addr = '0;
    src_tuse = '0;
    repeat (DEPTH) step();
  endtask

  task automatic issue(input logic [ADDR_W-1:0] wa, input logic [1:0] tnew);
    issue_valid = 1'b1; issue_we = 1'b1; issue_wa = wa; issue_tnew = tnew;
  endtask

  initial begin
    reset = 1'b1;
    idle();
    src_addr   = '0;
    src_tuse   = '0;
    src_rfdata = {32'hBBBB_0001, 32'hAAAA_0000};
    stage_data = {32'h0000_9ABC, 32'h0000_5678, 32'h0000_1234};
    step(); step();
    reset = 1'b0;

    // Post-reset state.
    src_addr = {5'd4, 5'd3};
    #3;
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_ready", 32'(src_ready), 32'h3);
    chk("rst_fwd0", src_fwd[31:0], 32'hAAAA_0000);
    drain();

    // Forward tnew=0 producer from E.
    issue(5'd8, 2'd0);
    step();
    idle();
    src_addr = {5'd0, 5'd8};
    #3;
    chk("e_fwd0", src_fwd[31:0], 32'h0000_1234);
    chk("e_stall", 32'(stall), 32'd0);
    drain();

    // Load-use: two stall cycles, then forward from W.
    issue(5'd9, 2'd2);
    step();
    idle();
    src_addr = {5'd0, 5'd9};
    src_tuse = '0;
    #3; chk("load_stall1", 32'(stall), 32'd1);
    step();
    #3; chk("load_stall2", 32'(stall), 32'd1);
    step();
    #3;
    chk("load_stall3", 32'(stall), 32'd0);
    chk("load_fwd0", src_fwd[31:0], 32'h0000_9ABC);
    chk("load_ready0", 32'(src_ready[0]), 32'd1);
    drain();

    // Youngest of two matches wins; both ports agree.
    issue(5'd5, 2'd0); step();
    issue(5'd5, 2'd0); step();
    idle();
    src_addr = {5'd5, 5'd5};
    #3;
    chk("young_fwd0", src_fwd[31:0], 32'h0000_1234);
    chk("young_fwd1", src_fwd[63:32], 32'h0000_1234);
    drain();

    // Late producer but consumer is later still: not ready, no stall.
    issue(5'd6, 2'd2); step();
    idle();
    src_addr = {5'd0, 5'd6};
    src_tuse = {2'd0, 2'd2};
    #3;
    chk("late_ready0", 32'(src_ready[0]), 32'd0);
    chk("late_stall", 32'(stall), 32'd0);
    chk("late_fwd0", src_fwd[31:0], 32'hAAAA_0000);
    drain();

    // Register 0 never forwards or stalls.
    issue(5'd0, 2'd2); step();
    idle();
    src_addr = '0;
    #3;
    chk("r0_stall", 32'(stall), 32'd0);
    chk("r0_fwd0", src_fwd[31:0], 32'hAAAA_0000);
    drain();

    // Flushed issue never enters the pipeline.
    issue(5'd7, 2'd0);
    flush = 1'b1;
    step();
    idle();
    src_addr = {5'd0, 5'd7};
    #3;
    chk("flush_fwd0", src_fwd[31:0], 32'hAAAA_0000);
    chk("flush_ready0", 32'(src_ready[0]), 32'd1);
    drain();

    // Reset forgets a pending producer.
    issue(5'd3, 2'd2); step();
    idle();
    reset = 1'b1; step();
    reset = 1'b0;
    src_addr = {5'd0, 5'd3};
    #3;
    chk("rst_mid_stall", 32'(stall), 32'd0);
    chk("rst_mid_ready0", 32'(src_ready[0]), 32'd1);
    drain();

    // Mixed traffic, checked by the model only.
    for (int i = 0; i < 40; i++) begin
      issue_valid = (i % 3) != 2;
      issue_we    = (i % 5) != 4;
      issue_wa    = ADDR_W'((i * 3) % 8);
      issue_tnew  = 2'(i % 4);
      flush       = (i % 7) == 6;
      src_addr    = {ADDR_W'((i + 2) % 8), ADDR_W'((i * 5) % 8)};
      src_tuse    = {2'((i / 2) % 4), 2'(i % 3)};
      src_rfdata  = {32'hBB00_0000 + 32'(i), 32'hAA00_0000 + 32'(i)};
      stage_data  = {32'h3000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i)};
      step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/operand_bypass.md
OPERAND_BYPASS -- requirements
Module: operand_bypass

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand/result width.
REQ-002 SHALL have parameter ADDR_W, default 5: GRF address width.
REQ-003 SHALL have parameter NUM_SRC, default 2: number of D-stage read ports (1..4).
REQ-004 SHALL have parameter DEPTH, default 3: tracked stages after D (index 0=E, 1=M, 2=W; legal 2..4).
REQ-005 SHALL have port clk, input, 1: single clock, rising edge.
REQ-006 SHALL have port reset, input, 1: synchronous, active-high.
REQ-007 SHALL have port issue_valid, input, 1: instruction in D advances to E this cycle.
REQ-008 SHALL have port issue_we, input, 1: issuing instruction writes GRF.
REQ-009 SHALL have port issue_wa, input, ADDR_W: destination register.
REQ-010 SHALL have port issue_tnew, input, 2: cycles after E entry until result is valid.
REQ-011 SHALL have port flush, input, 1: kill instruction entering E.
REQ-012 SHALL have port src_addr, input, NUM_SRC*ADDR_W: source register per port.
REQ-013 SHALL have port src_tuse, input, NUM_SRC*2: cycles until operand is consumed.
REQ-014 SHALL have port src_rfdata, input, NUM_SRC*DATA_W: GRF read data per port.
REQ-015 SHALL have port stage_data, input, DEPTH*DATA_W: result bus of each tracked stage.
REQ-016 SHALL have port src_fwd, output, NUM_SRC*DATA_W: bypassed operand per port.
REQ-017 SHALL have port src_ready, output, NUM_SRC: src_fwd is final.
REQ-018 SHALL have port stall, output, 1: freeze PC/D, bubble into E.

Function
REQ-019 Each stage entry SHALL hold valid, we, wa, tnew.
REQ-020 Every clock, entries k SHALL shift to k+1 (last entry dropped); tnew decrements on shift, saturating at 0.
REQ-021 Entry 0 SHALL load issue fields when issue_valid=1, stall=0, flush=0; otherwise SHALL load a bubble (valid=0).
REQ-022 Precedence: reset > flush > stall > issue_valid.
REQ-023 Per port, match = valid & we & wa==src_addr & src_addr!=0; the youngest matching stage (lowest k) SHALL win.
REQ-024 No match: src_fwd=src_rfdata, src_ready=1.
REQ-025 Winning match with tnew==0: src_fwd=stage_data[k], src_ready=1.
REQ-026 Winning match with 0<tnew<=src_tuse: src_fwd=src_rfdata, src_ready=0, no stall.
REQ-027 Winning match with tnew>src_tuse: port hazard; stall=OR of all port hazards.
REQ-028 Register 0 SHALL never forward or stall.
REQ-029 Outputs SHALL be combinational from registered entries and current inputs (zero-cycle latency); state updates take effect next cycle.
REQ-030 Two ports naming the same register SHALL resolve independently and identically.

Reset
REQ-031 reset=1 at a clock edge SHALL clear all entry valid bits, including mid-operation; pending writes are forgotten.
REQ-032 After reset: stall=0, src_ready all 1, src_fwd=src_rfdata.

Structure
REQ-033 A shared package SHALL hold stage-index constants (STG_E, STG_M, STG_W), TNEW_W=2, and the stage-entry typedef.
REQ-034 One sub-module, bypass_pick, SHALL perform the per-port priority search and be instantiated NUM_SRC times.

Verification
REQ-035 Issue we=1 wa=8 tnew=0; next cycle src_addr0=8, stage_data[E]=0x1234 -> src_fwd0=0x1234, stall=0.
REQ-036 Issue wa=9 tnew=2 (load); next cycle src_addr0=9 tuse=0 -> stall=1 for 2 cycles, then src_fwd0=stage_data[W], stall=0.
REQ-037 Entry E wa=5 and entry M wa=5, both tnew=0 -> src_fwd=stage_data[E] (youngest wins).
REQ-038 Issue wa=0 tnew=2; src_addr=0 -> stall=0, src_fwd=src_rfdata.
REQ-039 Issue wa=7 with flush=1; next cycle src_addr=7 -> no match, src_fwd=src_rfdata.
REQ-040 Issue wa=3 tnew=2, assert reset 1 cycle; next cycle src_addr=3 -> stall=0, src_ready=1.
